stack_reg_unit: RTL and testbench

Register/stack unit of the 8-bit CPU that owns the `eip`, `ebp` and `esp` pointer registers. It feeds them to the downstream register-output selector every cycle. It executes stack-class operations (PUSH, POP, CALL, RET, ENTER, LEAVE, JMP) against a single-port data memory using a req/ack handshake, and advances `eip` on fetch-step requests.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/stack_reg_unit.sv | 201 ++++++++++++++++++++
 tb/tb_stack_reg_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: pointer width, stack-op encoding
// and the stack/register unit state type.
package cpu_pkg;

  localparam int PTR_W = 8;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_ENTER = 3'd5;
  localparam logic [2:0] OP_LEAVE = 3'd6;
  localparam logic [2:0] OP_JMP   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/stack_reg_unit.sv
// Owns eip/ebp/esp and runs stack-class ops against a single-port memory
// over a registered req/ack handshake; eip also advances on fetch steps.
module stack_reg_unit
  import cpu_pkg::*;
#(
  parameter logic [PTR_W-1:0] STACK_TOP    = 8'hFF,
  parameter logic [PTR_W-1:0] STACK_BOTTOM = 8'h80,
  parameter logic [PTR_W-1:0] EIP_RESET    = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [PTR_W-1:0] op_data,
  input  logic [PTR_W-1:0] op_target,
  input  logic             eip_inc,
  input  logic [1:0]       eip_step,
  output logic [PTR_W-1:0] eip,
  output logic [PTR_W-1:0] ebp,
  output logic [PTR_W-1:0] esp,
  output logic [PTR_W-1:0] pop_data,
  output logic             done,
  output logic             fault,
  output logic             mem_req,
  output logic             mem_we,
  output logic [PTR_W-1:0] mem_addr,
  output logic [PTR_W-1:0] mem_wdata,
  input  logic [PTR_W-1:0] mem_rdata,
  input  logic             mem_ack,
  output state_e           dbg_state
);

  // Handshake: an op is taken on a rising edge with op_valid && op_ready.
  // mem_req/we/addr/wdata are held until mem_ack is sampled high.
  state_e           r_state,     w_nxt_state;
  logic [2:0]       r_op,        w_nxt_op;
  logic [PTR_W-1:0] r_target,    w_nxt_target;
  logic [PTR_W-1:0] r_eip,       w_nxt_eip;
  logic [PTR_W-1:0] r_ebp,       w_nxt_ebp;
  logic [PTR_W-1:0] r_esp,       w_nxt_esp;
  logic [PTR_W-1:0] r_pop_data,  w_nxt_pop_data;
  logic             r_done,      w_nxt_done;
  logic             r_fault,     w_nxt_fault;
  logic             r_mem_req,   w_nxt_mem_req;
  logic             r_mem_we,    w_nxt_mem_we;
  logic [PTR_W-1:0] r_mem_addr,  w_nxt_mem_addr;
  logic [PTR_W-1:0] r_mem_wdata, w_nxt_mem_wdata;

  logic             w_accept;
  logic [PTR_W-1:0] w_esp_dec;
  logic [PTR_W-1:0] w_esp_inc;
  logic [PTR_W-1:0] w_ebp_inc;
  logic             w_full;
  logic             w_empty;
  logic             w_frame_empty;

  assign op_ready      = (r_state == ST_IDLE);
  assign w_accept      = op_valid && op_ready;
  assign w_esp_dec     = r_esp - 8'd1;
  assign w_esp_inc     = r_esp + 8'd1;
  assign w_ebp_inc     = r_ebp + 8'd1;
  assign w_full        = (r_esp == STACK_BOTTOM);
  assign w_empty       = (r_esp == STACK_TOP);
  assign w_frame_empty = (r_ebp == STACK_TOP);

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_op        = r_op;
    w_nxt_target    = r_target;
    w_nxt_eip       = r_eip;
    w_nxt_ebp       = r_ebp;
    w_nxt_esp       = r_esp;
    w_nxt_pop_data  = r_pop_data;
    w_nxt_done      = 1'b0;
    w_nxt_fault     = 1'b0;
    w_nxt_mem_req   = r_mem_req;
    w_nxt_mem_we    = r_mem_we;
    w_nxt_mem_addr  = r_mem_addr;
    w_nxt_mem_wdata = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nxt_op     = op;
          w_nxt_target = op_target;
          case (op)
            OP_PUSH, OP_CALL, OP_ENTER: begin
              if (w_full) begin
                w_nxt_fault = 1'b1;
              end else begin
                w_nxt_state     = ST_WR_WAIT;
                w_nxt_mem_req   = 1'b1;
                w_nxt_mem_we    = 1'b1;
                w_nxt_mem_addr  = w_esp_dec;
                w_nxt_mem_wdata = (op == OP_PUSH) ? op_data :
                                  (op == OP_CALL) ? r_eip : r_ebp;
              end
            end
            OP_POP, OP_RET, OP_LEAVE: begin
              if ((op == OP_LEAVE) ? w_frame_empty : w_empty) begin
                w_nxt_fault = 1'b1;
              end else begin
                w_nxt_state    = ST_RD_WAIT;
                w_nxt_mem_req  = 1'b1;
                w_nxt_mem_we   = 1'b0;
                w_nxt_mem_addr = (op == OP_LEAVE) ? r_ebp : r_esp;
              end
            end
            OP_JMP: begin
              w_nxt_eip  = op_target;
              w_nxt_done = 1'b1;
            end
            default: ;
          endcase
        end else if (eip_inc) begin
          w_nxt_eip = r_eip + {6'd0, eip_step};
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        // esp/ebp cannot move while waiting, so the shared +/-1 still
        // matches the address issued at accept.
        if (mem_ack) begin
          w_nxt_state   = ST_IDLE;
          w_nxt_mem_req = 1'b0;
          w_nxt_mem_we  = 1'b0;
          w_nxt_done    = 1'b1;
          case (r_op)
            OP_PUSH:  w_nxt_esp = w_esp_dec;
            OP_CALL: begin
              w_nxt_esp = w_esp_dec;
              w_nxt_eip = r_target;
            end
            OP_ENTER: begin
              w_nxt_esp = w_esp_dec;
              w_nxt_ebp = w_esp_dec;
            end
            OP_POP: begin
              w_nxt_pop_data = mem_rdata;
              w_nxt_esp      = w_esp_inc;
            end
            OP_RET: begin
              w_nxt_eip = mem_rdata;
              w_nxt_esp = w_esp_inc;
            end
            OP_LEAVE: begin
              w_nxt_ebp = mem_rdata;
              w_nxt_esp = w_ebp_inc;
            end
            default: ;
          endcase
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_target    <= '0;
      r_eip       <= EIP_RESET;
      r_ebp       <= STACK_TOP;
      r_esp       <= STACK_TOP;
      r_pop_data  <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_op        <= w_nxt_op;
      r_target    <= w_nxt_target;
      r_eip       <= w_nxt_eip;
      r_ebp       <= w_nxt_ebp;
      r_esp       <= w_nxt_esp;
      r_pop_data  <= w_nxt_pop_data;
      r_done      <= w_nxt_done;
      r_fault     <= w_nxt_fault;
      r_mem_req   <= w_nxt_mem_req;
      r_mem_we    <= w_nxt_mem_we;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_wdata <= w_nxt_mem_wdata;
    end
  end

  assign eip       = r_eip;
  assign ebp       = r_ebp;
  assign esp       = r_esp;
  assign pop_data  = r_pop_data;
  assign done      = r_done;
  assign fault     = r_fault;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_stack_reg_unit.sv
// Directed bench for stack_reg_unit: the driver queues the expected pointer
// snapshot for each op, a monitor checks it when done/fault pulses.
module tb_stack_reg_unit;
  import cpu_pkg::*;

  localparam int W = 33;  // {fault, esp, ebp, eip, pop_data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] op = 3'd0;
  logic [7:0] op_data = 8'd0;
  logic [7:0] op_target = 8'd0;
  logic       eip_inc = 1'b0;
  logic [1:0] eip_step = 2'd0;
  logic [7:0] eip, ebp, esp, pop_data;
  logic       done, fault;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
  logic       mem_ack = 1'b0;
  state_e     dbg_state;

  stack_reg_unit dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .op_data(op_data), .op_target(op_target),
    .eip_inc(eip_inc), .eip_step(eip_step),
    .eip(eip), .ebp(ebp), .esp(esp), .pop_data(pop_data),
    .done(done), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  int mem_wait = 0;
  int wcnt = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst_n && mem_req) begin
        if (wcnt >= mem_wait) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && (done || fault)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: done=%0b fault=%0b with no op pending", done, fault);
      end else begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        e = exp_q.pop_front();
        a = {fault, esp, ebp, eip, pop_data};
        if (done && fault) begin
          n_fail++;
          $display("FAIL done_and_fault: both pulses high");
        end else if (a !== e) begin
          n_fail++;
          $display("FAIL result: got fault/esp/ebp/eip/pop=%0b/%h/%h/%h/%h expected %0b/%h/%h/%h/%h",
                   a[32], a[31:24], a[23:16], a[15:8], a[7:0],
                   e[32], e[31:24], e[23:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic [2:0] o, input logic [7:0] d, input logic [7:0] tgt,
                       input int waits, input logic inc, input logic [1:0] step,
                       input logic x_fault, input logic x_mem, input logic x_we,
                       input logic [7:0] x_addr, input logic [7:0] x_wdata,
                       input logic [7:0] x_esp, input logic [7:0] x_ebp,
                       input logic [7:0] x_eip, input logic [7:0] x_pop);
    int  n;
    int  lat;
    bit  seen_req;
    bit  finished;
    @(negedge clk);
    chk("op_ready_before", {31'd0, op_ready}, 32'd1);
    mem_wait  = waits;
    op_valid  = 1'b1;
    op        = o;
    op_data   = d;
    op_target = tgt;
    eip_inc   = inc;
    eip_step  = step;
    exp_q.push_back({x_fault, x_esp, x_ebp, x_eip, x_pop});
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
    op        = OP_NOP;
    op_target = 8'h00;
    eip_inc   = 1'b0;
    lat       = x_mem ? waits + 1 : 0;
    n = 0; seen_req = 0; finished = 0;
    while (n <= 40) begin
      if (mem_req) begin
        seen_req = 1;
        chk("mem_we",   {31'd0, mem_we}, {31'd0, x_we});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, x_addr});
        if (x_we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, x_wdata});
      end
      if (done || fault) begin
        finished = 1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("completion_seen", {31'd0, finished}, 32'd1);
    chk("latency", n, lat);
    chk("mem_req_seen", {31'd0, seen_req}, {31'd0, x_mem});
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eip", {24'd0, eip}, 32'h00);
    chk("rst_esp", {24'd0, esp}, 32'hFF);
    chk("rst_ebp", {24'd0, ebp}, 32'hFF);
    chk("rst_pop", {24'd0, pop_data}, 32'h00);
    chk("rst_pulses", {28'd0, done, fault, mem_req, mem_we}, 32'd0);
    chk("rst_addr_wdata", {16'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // PUSH/POP with waits; addr/data held through wait cycles
    do_op(OP_PUSH, 8'hA5, 8'h00, 2, 0, 0, 0, 1, 1, 8'hFE, 8'hA5, 8'hFE, 8'hFF, 8'h00, 8'h00);
    do_op(OP_PUSH, 8'h11, 8'h00, 0, 0, 0, 0, 1, 1, 8'hFD, 8'h11, 8'hFD, 8'hFF, 8'h00, 8'h00);
    do_op(OP_POP,  8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'hFD, 8'h00, 8'hFE, 8'hFF, 8'h00, 8'h11);
    do_op(OP_POP,  8'h00, 8'h00, 1, 0, 0, 0, 1, 0, 8'hFE, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hA5);

    // JMP, CALL, RET
    do_op(OP_JMP,  8'h00, 8'h10, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h10, 8'hA5);
    do_op(OP_CALL, 8'h00, 8'h40, 0, 0, 0, 0, 1, 1, 8'hFE, 8'h10, 8'hFE, 8'hFF, 8'h40, 8'hA5);
    chk("mem_FE_after_call", {24'd0, mem[8'hFE]}, 32'h10);
    do_op(OP_RET,  8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'hFE, 8'h00, 8'hFF, 8'hFF, 8'h10, 8'hA5);

    // empty-stack faults
    do_op(OP_POP,   8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h10, 8'hA5);
    do_op(OP_RET,   8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h10, 8'hA5);
    do_op(OP_LEAVE, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h10, 8'hA5);

    // ENTER / LEAVE
    do_op(OP_ENTER, 8'h00, 8'h00, 1, 0, 0, 0, 1, 1, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'h10, 8'hA5);
    do_op(OP_LEAVE, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'hFE, 8'h00, 8'hFF, 8'hFF, 8'h10, 8'hA5);

    // eip_inc alone, then alongside an accepted PUSH (dropped)
    @(negedge clk);
    eip_inc = 1'b1; eip_step = 2'd2;
    @(posedge clk);
    #1;
    eip_inc = 1'b0;
    chk("eip_inc_step2", {24'd0, eip}, 32'h12);
    do_op(OP_PUSH, 8'h33, 8'h00, 0, 1, 2, 0, 1, 1, 8'hFE, 8'h33, 8'hFE, 8'hFF, 8'h12, 8'hA5);
    do_op(OP_POP,  8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'hFE, 8'h00, 8'hFF, 8'hFF, 8'h12, 8'h33);

    // eip wraps modulo 256
    do_op(OP_JMP,  8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h33);
    @(negedge clk);
    eip_inc = 1'b1; eip_step = 2'd3;
    @(posedge clk);
    #1;
    eip_inc = 1'b0;
    chk("eip_inc_wrap", {24'd0, eip}, 32'h02);

    // NOP: accepted silently
    @(negedge clk);
    op_valid = 1'b1; op = OP_NOP;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("nop_no_effect", {esp, ebp, eip, 7'd0, mem_req}, {8'hFF, 8'hFF, 8'h02, 8'h00});

    // fill to STACK_BOTTOM, then overflow faults
    for (int i = 0; i < 127; i++) begin
      logic [7:0] a;
      a = 8'hFE - 8'(i);
      do_op(OP_PUSH, 8'(i), 8'h00, 0, 0, 0, 0, 1, 1, a, 8'(i), a, 8'hFF, 8'h02, 8'h33);
    end
    do_op(OP_PUSH,  8'h55, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h02, 8'h33);
    do_op(OP_CALL,  8'h00, 8'h44, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h02, 8'h33);
    do_op(OP_ENTER, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h02, 8'h33);

    // asynchronous reset while a request is outstanding
    @(negedge clk);
    mem_wait = 20;
    op_valid = 1'b1; op = OP_POP;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = OP_NOP;
    @(posedge clk);
    #1;
    chk("req_before_reset", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_req_drop", {30'd0, mem_req, mem_we}, 32'd0);
    chk("reset_ptrs", {esp, ebp, eip, pop_data}, 32'hFFFF0000);
    chk("reset_addr_wdata", {16'd0, mem_addr, mem_wdata}, 32'd0);
    chk("reset_ready", {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("after_reset_idle", {30'd0, mem_req, done}, 32'd0);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
